// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES (inverse) SubBytes: LANES S-box lanes process NBYTES/LANES beats per block.
// Optional macro SUB_BYTES_FWD_EN adds a forward S-box per lane, selected by the registered mode.
module inv_sub_bytes_iter #(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  localparam int unsigned NBEATS = NBYTES / LANES;
  localparam int unsigned CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned DW     = 8 * NBYTES;
  localparam int unsigned LW     = 8 * LANES;
  localparam int unsigned IW     = $clog2(DW);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_TBL[{~x, 3'b000} +: 8];
  endfunction

`ifdef SUB_BYTES_FWD_EN
  localparam logic [2047:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    return FWD_TBL[{~x, 3'b000} +: 8];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_beat;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_result;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;
  logic [IW-1:0]   w_base;
  logic [LW-1:0]   w_beat_in;
  logic [LW-1:0]   w_beat_out;

`ifdef SUB_BYTES_FWD_EN
  logic            r_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_mode <= mode;
    end
  end
`else
  logic            w_unused_mode;
  assign w_unused_mode = mode;
`endif

  // Bytes handled this beat are the contiguous slice selected by the beat counter.
  assign w_base    = IW'(r_cnt) * IW'(LW);
  assign w_beat_in = r_result[w_base +: LW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] w_in;
    assign w_in = w_beat_in[8*l +: 8];
`ifdef SUB_BYTES_FWD_EN
    assign w_beat_out[8*l +: 8] = r_mode ? inv_sbox(w_in) : fwd_sbox(w_in);
`else
    assign w_beat_out[8*l +: 8] = inv_sbox(w_in);
`endif
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_beat   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        w_beat = 1'b1;
        if (r_cnt == LAST_BEAT) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      r_busy      <= (w_next == BUSY);
      if (w_accept) begin
        r_result <= in_data;
        r_cnt    <= '0;
      end else if (w_beat) begin
        r_result[w_base +: LW] <= w_beat_out;
        if (r_cnt != LAST_BEAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_result;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Scoreboard bench for inv_sub_bytes_iter: driver queues expected blocks, negedge monitor checks them.
module tb_inv_sub_bytes_iter;
  parameter int unsigned LANES = 4;
  localparam int unsigned NBYTES = 16;
  localparam int unsigned NBEATS = NBYTES / LANES;
  localparam int unsigned DW     = 8 * NBYTES;
  localparam time         PERIOD = 10;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;

  typedef struct {
    logic [DW-1:0] data;
    time           t_acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_push = 0;
  int   n_xfer = 0;
  logic prev_valid = 1'b0;

  inv_sub_bytes_iter #(.NBYTES(NBYTES), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on each out_valid rise, data on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending block");
        end else begin
          check("latency", DW'($time - q[0].t_acc), DW'((NBEATS + 1) * PERIOD));
        end
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_transfer: got data %h expected none", out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", out_data, e.data);
          n_xfer++;
        end
      end
      prev_valid = out_valid;
    end
  end

  // Called at a negedge; presents one block and returns at the following negedge.
  task automatic send(input logic [DW-1:0] d, input logic m, input logic [DW-1:0] exp, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    if (push) begin
      q.push_back('{data: exp, t_acc: $time});
      n_push++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #(200000 * PERIOD);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v63, v0, v2, e2, e52, vp, ep_inv, ep_fwd, held;
    logic [7:0]    p_in[5];
    logic [7:0]    p_inv[5];
    logic [7:0]    p_fwd[5];
    int            done_cnt;
    bit            have;

    p_in  = '{8'h52, 8'h09, 8'hFF, 8'h01, 8'h63};
    p_inv = '{8'h48, 8'h40, 8'h7D, 8'h09, 8'h00};
    p_fwd = '{8'h00, 8'h01, 8'h16, 8'h7C, 8'hFB};
    v63 = {16{8'h63}};
    v0  = '0;
    e52 = {16{8'h52}};
    v2  = {8'h16, 112'h0, 8'h7C};
    e2  = {8'hFF, {14{8'h52}}, 8'h01};
    for (int j = 0; j < 16; j++) begin
      vp[8*j +: 8]     = p_in[j % 5];
      ep_inv[8*j +: 8] = p_inv[j % 5];
      ep_fwd[8*j +: 8] = p_fwd[j % 5];
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_out_data", out_data, '0);
    rst = 1'b0;
    @(negedge clk);

    send(v63, 1'b1, '0, 1'b1);
    send(v2, 1'b1, e2, 1'b1);
    send(vp, 1'b1, ep_inv, 1'b1);
    send(v0, 1'b1, e52, 1'b1);
`ifdef SUB_BYTES_FWD_EN
    send(v0, 1'b0, v63, 1'b1);
    send(vp, 1'b0, ep_fwd, 1'b1);
    send(v63, 1'b0, {16{8'hFB}}, 1'b1);
`else
    send(v0, 1'b0, e52, 1'b1);
    send(vp, 1'b0, ep_inv, 1'b1);
    send(v63, 1'b0, '0, 1'b1);
`endif

    // Stall in DONE while the input side keeps toggling.
    wait_drain();
    out_ready = 1'b0;
    send(v2, 1'b1, e2, 1'b1);
    done_cnt = 0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 60 && done_cnt < 10; i++) begin
      check("stall_in_ready", DW'(in_ready), DW'(0));
      if (out_valid) begin
        if (!have) begin
          held = out_data;
          have = 1'b1;
        end else begin
          check("stall_data_stable", out_data, held);
        end
        done_cnt++;
      end
      in_valid = i[0];
      in_data  = {4{$urandom}};
      mode     = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_done_cycles", DW'(done_cnt), DW'(10));
    out_ready = 1'b1;
    @(negedge clk);
    check("post_xfer_out_valid", DW'(out_valid), DW'(0));
    check("post_xfer_in_ready", DW'(in_ready), DW'(1));

    // Reset on beat 2 abandons the block.
    send(v63, 1'b1, '0, 1'b0);
    check("busy_after_accept", DW'(busy), DW'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", DW'(in_ready), DW'(1));
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_out_valid", DW'(out_valid), DW'(0));
    check("abort_out_data", out_data, '0);
    repeat (NBEATS + 6) @(negedge clk);
    send(v2, 1'b1, e2, 1'b1);

    // Reset wins over a simultaneous accept.
    wait_drain();
    @(negedge clk);
    in_valid = 1'b1; in_data = v63; mode = 1'b1; rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    check("rst_prio_busy", DW'(busy), DW'(0));
    check("rst_prio_in_ready", DW'(in_ready), DW'(1));
    repeat (NBEATS + 4) @(negedge clk);
    send(vp, 1'b1, ep_inv, 1'b1);

    wait_drain();
    repeat (3) @(negedge clk);
    check("xfer_count", DW'(n_xfer), DW'(n_push));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 SHALL have parameter NBYTES, default 16, meaning state width in bytes (data width = 8*NBYTES).
REQ-002 SHALL have parameter LANES, default 4, meaning number of invSbox instances used per cycle; legal values divide NBYTES.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, 8*NBYTES, meaning the state to substitute; byte j = in_data[8j+7:8j].
REQ-008 SHALL have port mode, input, 1, meaning 1 = inverse S-box, 0 = forward S-box; sampled with in_data.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data holds a completed result.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-011 SHALL have port out_data, output, 8*NBYTES, meaning the substituted state, same byte ordering as in_data.
REQ-012 SHALL have port busy, output, 1, meaning the block is in BUSY.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert in_ready only in IDLE; the input is accepted on in_valid && in_ready.
REQ-015 On accept: SHALL register in_data and mode, clear beat counter to 0, and go to BUSY.
REQ-016 In BUSY, beat k SHALL substitute bytes k*LANES .. k*LANES+LANES-1 through LANES S-box lanes and write the results into the result register; untouched bytes hold their value.
REQ-017 Counter width SHALL be clog2(NBYTES/LANES), minimum 1; after beat NBYTES/LANES-1 the FSM SHALL go to DONE, with no wrap-around back into BUSY.
REQ-018 Latency, accept edge to first out_valid high, SHALL be exactly NBYTES/LANES cycles; LANES = NBYTES gives 1 cycle.
REQ-019 In DONE, out_valid SHALL be 1 and out_data SHALL stay stable until out_valid && out_ready; then the FSM SHALL go to IDLE.
REQ-020 SHALL not accept new input in the same cycle as the output handshake; the next accept is earliest one cycle later, so throughput is one block per NBYTES/LANES+2 cycles.
REQ-021 out_ready held low SHALL stall in DONE indefinitely with no loss or corruption.
REQ-022 in_valid while BUSY or DONE SHALL be ignored, and the in_data change SHALL have no effect on the result in progress.
REQ-023 out_data SHALL be driven from the result register only, with no combinational path from in_data.
REQ-024 busy SHALL be 1 exactly when state = BUSY.

Reset
REQ-025 rst = 1 at a clock edge SHALL force IDLE, beat counter 0, result register 0, out_valid 0, busy 0, in_ready 1 on the next cycle.
REQ-026 Reset mid-BUSY or mid-DONE SHALL abandon the block, and no out_valid SHALL follow for it.
REQ-027 rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-028 Macro SUB_BYTES_FWD_EN defined: each lane SHALL also instantiate a forward sbox, and the registered mode selects the sbox or invSbox output per beat.
REQ-029 SUB_BYTES_FWD_EN undefined: no forward sbox SHALL be instantiated, mode SHALL be ignored, and every block SHALL be inverse-substituted.

Verification
REQ-030 NBYTES=16, LANES=4, mode=1, in_data all bytes 0x63 -> out_valid 4 cycles after accept, out_data = 128'h0.
REQ-031 mode=1, byte0=0x7C, byte15=0x16, others 0x00 -> byte0 0x01, byte15 0xFF, others 0x52.
REQ-032 out_ready low for 10 cycles in DONE with in_valid toggling and in_data changing -> out_data stable, in_ready 0, one transfer only when out_ready rises.
REQ-033 rst pulsed on beat 2 of BUSY -> next cycle IDLE, in_ready 1, out_valid never asserted for that block; following block correct.
REQ-034 LANES=16 and LANES=1 builds -> latency 1 and 16 cycles respectively, identical results to LANES=4.
REQ-035 SUB_BYTES_FWD_EN defined, mode=0, all bytes 0x00 -> all bytes 0x63; undefined, same stimulus -> all bytes 0x52.
